// File: rtl/full_pipeline_mul_stream_if.sv
`default_nettype none
// ============================================================================
// Module   : full_pipeline_mul_stream_if
// Purpose  : Stream bundle for full_pipeline_mul_stream. It carries the
//            operand stream (valid/ready, signed mode, operands), the result
//            stream (valid/ready, result, clip flag) and the saturation
//            counter with its clear.
// Modports : master - drives operands, out_ready and sat_clr
//            slave  - the multiplier side; drives in_ready, results, sat_cnt
// Revision : 1.0 - initial release
// ============================================================================
interface full_pipeline_mul_stream_if #(
    parameter int DIN0_W = 16,
    parameter int DIN1_W = 16,
    parameter int DOUT_W = 16,
    parameter int CNT_W  = 16
);
    logic              in_valid;
    logic              in_ready;
    logic              in_signed;
    logic [DIN0_W-1:0] din0;
    logic [DIN1_W-1:0] din1;
    logic              out_valid;
    logic              out_ready;
    logic [DOUT_W-1:0] dout;
    logic              out_sat;
    logic [CNT_W-1:0]  sat_cnt;
    logic              sat_clr;

    modport master (
        output in_valid, in_signed, din0, din1, out_ready, sat_clr,
        input  in_ready, out_valid, dout, out_sat, sat_cnt
    );

    modport slave (
        input  in_valid, in_signed, din0, din1, out_ready, sat_clr,
        output in_ready, out_valid, dout, out_sat, sat_cnt
    );
endinterface
`default_nettype wire

// File: rtl/full_pipeline_mul_stream.sv
`default_nettype none
// ============================================================================
// Module   : full_pipeline_mul_stream
// Purpose  : Pipelined signed/unsigned multiplier with a valid/ready stream
//            interface, global-stall backpressure and fixed-point
//            post-scaling (round half-up or floor, arithmetic right shift,
//            saturation to DOUT_W). It also counts delivered clipped results.
// Ports    : clk   - rising-edge clock
//            reset - asynchronous, active-low reset
//            bus   - stream bundle (slave modport): operands in, results out,
//                    sat_cnt / sat_clr
// Pipeline : stage 1 = product, stage 2 = round/shift (when NUM_STAGE >= 2),
//            any further stages = delay, last stage = saturate into the
//            output register. With NUM_STAGE = 1 all three happen in the
//            output register stage.
// Revision : 1.0 - initial release
// ============================================================================
module full_pipeline_mul_stream #(
    parameter int DIN0_W    = 16,
    parameter int DIN1_W    = 16,
    parameter int DOUT_W    = 16,
    parameter int NUM_STAGE = 3,
    parameter int SHIFT     = 8,
    parameter int ROUND_EN  = 1,
    parameter int CNT_W     = 16
) (
    input  wire logic               clk,
    input  wire logic               reset,
    full_pipeline_mul_stream_if.slave bus
);

    // Product width (one bit over DIN0_W+DIN1_W so unsigned products fit as
    // positive signed values); the datapath carries one extra bit on top so
    // the rounding add can never wrap.
    localparam int PW = DIN0_W + DIN1_W + 1;
    localparam int RND_POS = (SHIFT > 0) ? SHIFT - 1 : 0;

    localparam logic signed [PW:0] c_one  = 1;
    localparam logic signed [PW:0] c_smax = (c_one <<< (DOUT_W - 1)) - c_one;
    localparam logic signed [PW:0] c_smin = ~c_smax;
    localparam logic signed [PW:0] c_umax = (c_one <<< DOUT_W) - c_one;
    localparam logic signed [PW:0] c_rnd  =
        ((ROUND_EN != 0) && (SHIFT > 0)) ? (c_one <<< RND_POS) : '0;
    localparam logic [CNT_W-1:0]   c_cnt_max = '1;

    // Operands are extended to the full datapath width before multiplying so
    // the product is exact for both signed and unsigned interpretations.
    function automatic logic signed [PW:0] f_prod(
        input logic [DIN0_W-1:0] a,
        input logic [DIN1_W-1:0] b,
        input logic              sgn
    );
        logic              a_s;
        logic              b_s;
        logic signed [PW:0] a_w;
        logic signed [PW:0] b_w;
        a_s = sgn & a[DIN0_W-1];
        b_s = sgn & b[DIN1_W-1];
        a_w = {{(DIN1_W + 2){a_s}}, a};
        b_w = {{(DIN0_W + 2){b_s}}, b};
        return a_w * b_w;
    endfunction

    // Round (optional half-up) then arithmetic shift, i.e. floor division.
    function automatic logic signed [PW:0] f_rs(input logic signed [PW:0] x);
        logic signed [PW:0] t;
        t = x + c_rnd;
        return t >>> SHIFT;
    endfunction

    // Returns {clipped, value}.
    function automatic logic [DOUT_W:0] f_sat(
        input logic signed [PW:0] x,
        input logic               sgn
    );
        logic [DOUT_W:0] r;
        r = {1'b0, x[DOUT_W-1:0]};
        if (sgn) begin
            if (x > c_smax) begin
                r = {1'b1, c_smax[DOUT_W-1:0]};
            end else if (x < c_smin) begin
                r = {1'b1, c_smin[DOUT_W-1:0]};
            end
        end else begin
            if (x > c_umax) begin
                r = {1'b1, c_umax[DOUT_W-1:0]};
            end else if (x[PW]) begin
                r = {1'b1, {DOUT_W{1'b0}}};
            end
        end
        return r;
    endfunction

    logic               w_adv;
    logic signed [PW:0] w_pre;
    logic               w_pre_sgn;
    logic               w_pre_vld;
    logic [DOUT_W:0]    w_sat;

    logic               r_out_valid;
    logic [DOUT_W-1:0]  r_dout;
    logic               r_out_sat;
    logic [CNT_W-1:0]   r_sat_cnt;

    // Whole-pipe stall: everything moves only when the output slot frees up.
    assign w_adv        = !r_out_valid || bus.out_ready;
    assign bus.in_ready = w_adv;

    generate
        if (NUM_STAGE == 1) begin : g_single
            assign w_pre     = f_rs(f_prod(bus.din0, bus.din1, bus.in_signed));
            assign w_pre_sgn = bus.in_signed;
            assign w_pre_vld = bus.in_valid;
        end else begin : g_multi
            // Index 0 is stage 1; index NUM_STAGE-2 feeds the output stage.
            logic signed [PW:0] r_data [NUM_STAGE-1];
            logic               r_sgn  [NUM_STAGE-1];
            logic               r_vld  [NUM_STAGE-1];

            always_ff @(posedge clk or negedge reset) begin
                if (!reset) begin
                    for (int k = 0; k < NUM_STAGE - 1; k++) begin
                        r_vld[k] <= 1'b0;
                    end
                end else if (w_adv) begin
                    r_vld[0] <= bus.in_valid;
                    for (int k = 1; k < NUM_STAGE - 1; k++) begin
                        r_vld[k] <= r_vld[k-1];
                    end
                end
            end

            // Data registers need no reset: their valid bits gate them.
            always_ff @(posedge clk) begin
                if (w_adv) begin
                    r_data[0] <= f_prod(bus.din0, bus.din1, bus.in_signed);
                    r_sgn[0]  <= bus.in_signed;
                    for (int k = 1; k < NUM_STAGE - 1; k++) begin
                        r_data[k] <= (k == 1) ? f_rs(r_data[0]) : r_data[k-1];
                        r_sgn[k]  <= r_sgn[k-1];
                    end
                end
            end

            if (NUM_STAGE == 2) begin : g_two
                assign w_pre = f_rs(r_data[0]);
            end else begin : g_deep
                assign w_pre = r_data[NUM_STAGE-2];
            end
            assign w_pre_sgn = r_sgn[NUM_STAGE-2];
            assign w_pre_vld = r_vld[NUM_STAGE-2];
        end
    endgenerate

    assign w_sat = f_sat(w_pre, w_pre_sgn);

    // Output stage. Loading only when a valid sample arrives keeps dout and
    // out_sat steady across bubbles as well as stalls.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_out_valid <= 1'b0;
            r_dout      <= '0;
            r_out_sat   <= 1'b0;
        end else if (w_adv) begin
            r_out_valid <= w_pre_vld;
            if (w_pre_vld) begin
                r_out_sat <= w_sat[DOUT_W];
                r_dout    <= w_sat[DOUT_W-1:0];
            end
        end
    end

    // Clear has priority over a coincident increment; the count sticks at max.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_sat_cnt <= '0;
        end else if (bus.sat_clr) begin
            r_sat_cnt <= '0;
        end else if (r_out_valid && bus.out_ready && r_out_sat &&
                     (r_sat_cnt != c_cnt_max)) begin
            r_sat_cnt <= r_sat_cnt + 1'b1;
        end
    end

    assign bus.out_valid = r_out_valid;
    assign bus.dout      = r_dout;
    assign bus.out_sat   = r_out_sat;
    assign bus.sat_cnt   = r_sat_cnt;

endmodule
`default_nettype wire

// File: tb/tb_full_pipeline_mul_stream.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : tb_full_pipeline_mul_stream
// Purpose  : Directed self-checking bench. Instance A uses the default
//            parameters; instance B shares A's operand stream and out_ready
//            but truncates (ROUND_EN=0) and has a 2-bit saturation counter.
// Revision : 1.0 - initial release
// ============================================================================
module tb_full_pipeline_mul_stream;

    localparam int NS = 3;
    localparam int NV = 20;

    logic clk = 1'b0;
    logic reset = 1'b0;
    logic clr_b = 1'b0;

    always #5 clk = ~clk;

    full_pipeline_mul_stream_if #(.DIN0_W(16), .DIN1_W(16), .DOUT_W(16), .CNT_W(16)) bus ();
    full_pipeline_mul_stream_if #(.DIN0_W(16), .DIN1_W(16), .DOUT_W(16), .CNT_W(2))  busb ();

    assign busb.in_valid  = bus.in_valid;
    assign busb.in_signed = bus.in_signed;
    assign busb.din0      = bus.din0;
    assign busb.din1      = bus.din1;
    assign busb.out_ready = bus.out_ready;
    assign busb.sat_clr   = clr_b;

    full_pipeline_mul_stream #(
        .DIN0_W(16), .DIN1_W(16), .DOUT_W(16), .NUM_STAGE(NS),
        .SHIFT(8), .ROUND_EN(1), .CNT_W(16)
    ) dut_a (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    full_pipeline_mul_stream #(
        .DIN0_W(16), .DIN1_W(16), .DOUT_W(16), .NUM_STAGE(NS),
        .SHIFT(8), .ROUND_EN(0), .CNT_W(2)
    ) dut_b (
        .clk   (clk),
        .reset (reset),
        .bus   (busb)
    );

    int total = 0;
    int bad   = 0;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // One isolated sample with out_ready=1; checks latency and both results.
    task automatic send_one(input string tag, input logic sg, input logic [15:0] a,
                            input logic [15:0] b, input logic [15:0] ea, input logic sa,
                            input logic [15:0] eb, input logic clr_at_out);
        int lat;
        @(posedge clk); #1;
        bus.in_valid  = 1'b1;
        bus.in_signed = sg;
        bus.din0      = a;
        bus.din1      = b;
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
        end while (!bus.out_valid && lat < 20);
        check_val({tag, "_lat"}, lat, NS);
        check_val({tag, "_dout"}, {16'h0, bus.dout}, {16'h0, ea});
        check_val({tag, "_sat"}, {31'h0, bus.out_sat}, {31'h0, sa});
        check_val({tag, "_doutb"}, {16'h0, busb.dout}, {16'h0, eb});
        if (clr_at_out) bus.sat_clr = 1'b1;
        @(posedge clk); #1;
        bus.sat_clr = 1'b0;
    endtask

    // Stream vectors with hand-computed results for SHIFT=8, round half-up.
    logic        vs [NV];
    logic [15:0] va [NV];
    logic [15:0] vb [NV];
    logic [16:0] ve [NV];   // {out_sat, dout}
    logic [31:0] pat;
    logic [15:0] gap;

    initial begin
        int vi, oi, cyc, stale;
        logic hold, acc;
        logic [16:0] held;

        vs = '{1, 1, 1, 1, 1, 0, 1, 1, 0, 1, 1, 0, 1, 1, 1, 1, 1, 0, 1, 1};
        va = '{16'h0100, 16'h0180, 16'hFFFF, 16'h7FFF, 16'h8000, 16'hFFFF, 16'hFFFF,
               16'h0010, 16'hFFFF, 16'hFF00, 16'h0300, 16'h1234, 16'h00FF, 16'h0080,
               16'h007F, 16'hFF80, 16'hFF7F, 16'h8000, 16'h4000, 16'h4000};
        vb = '{16'h0100, 16'h0001, 16'hFFFF, 16'h7FFF, 16'h7FFF, 16'h0002, 16'h0002,
               16'h0010, 16'hFFFF, 16'h0100, 16'hFE00, 16'h0100, 16'h0001, 16'h0001,
               16'h0001, 16'h0001, 16'h0001, 16'h0002, 16'h0004, 16'h4000};
        ve = '{17'h00100, 17'h00002, 17'h00000, 17'h17FFF, 17'h18000, 17'h00200, 17'h00000,
               17'h00001, 17'h1FFFF, 17'h0FF00, 17'h0FA00, 17'h01234, 17'h00001, 17'h00001,
               17'h00000, 17'h00000, 17'h0FFFF, 17'h00100, 17'h00100, 17'h17FFF};
        pat = 32'b1011_0010_1110_0101_1001_1100_0110_1011;
        gap = 16'b1111_0111_1101_1111;

        bus.in_valid  = 1'b0;
        bus.in_signed = 1'b0;
        bus.din0      = '0;
        bus.din1      = '0;
        bus.out_ready = 1'b1;
        bus.sat_clr   = 1'b0;

        // Reset state
        #22;
        check_val("rst_valid", {31'h0, bus.out_valid}, 32'h0);
        check_val("rst_dout", {16'h0, bus.dout}, 32'h0);
        check_val("rst_sat", {31'h0, bus.out_sat}, 32'h0);
        check_val("rst_cnt", {16'h0, bus.sat_cnt}, 32'h0);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk); #1;
        check_val("rst_in_ready", {31'h0, bus.in_ready}, 32'h1);
        check_val("rst_in_ready_b", {31'h0, busb.in_ready}, 32'h1);

        // Latency, rounding, saturation, unsigned mode
        send_one("basic",  1'b1, 16'h0100, 16'h0100, 16'h0100, 1'b0, 16'h0100, 1'b0);
        send_one("round",  1'b1, 16'h0180, 16'h0001, 16'h0002, 1'b0, 16'h0001, 1'b0);
        send_one("m1m1",   1'b1, 16'hFFFF, 16'hFFFF, 16'h0000, 1'b0, 16'h0000, 1'b0);
        send_one("satpos", 1'b1, 16'h7FFF, 16'h7FFF, 16'h7FFF, 1'b1, 16'h7FFF, 1'b0);
        send_one("satneg", 1'b1, 16'h8000, 16'h7FFF, 16'h8000, 1'b1, 16'h8000, 1'b0);
        check_val("cnt2_a", {16'h0, bus.sat_cnt}, 32'd2);
        check_val("cnt2_b", {30'h0, busb.sat_cnt}, 32'd2);
        bus.sat_clr = 1'b1;
        @(posedge clk); #1;
        bus.sat_clr = 1'b0;
        check_val("cnt_clr", {16'h0, bus.sat_cnt}, 32'd0);
        send_one("sat3", 1'b1, 16'h7FFF, 16'h7FFF, 16'h7FFF, 1'b1, 16'h7FFF, 1'b0);
        send_one("sat4", 1'b1, 16'h7FFF, 16'h7FFF, 16'h7FFF, 1'b1, 16'h7FFF, 1'b0);
        send_one("sat5", 1'b1, 16'h7FFF, 16'h7FFF, 16'h7FFF, 1'b1, 16'h7FFF, 1'b0);
        check_val("cnt3_a", {16'h0, bus.sat_cnt}, 32'd3);
        check_val("cap_b", {30'h0, busb.sat_cnt}, 32'd3);
        send_one("satclr", 1'b1, 16'h7FFF, 16'h7FFF, 16'h7FFF, 1'b1, 16'h7FFF, 1'b1);
        check_val("clr_wins", {16'h0, bus.sat_cnt}, 32'd0);
        check_val("cap_b2", {30'h0, busb.sat_cnt}, 32'd3);
        send_one("uns",  1'b0, 16'hFFFF, 16'h0002, 16'h0200, 1'b0, 16'h01FF, 1'b0);
        send_one("sgn2", 1'b1, 16'hFFFF, 16'h0002, 16'h0000, 1'b0, 16'hFFFF, 1'b0);

        // Backpressured stream with bubbles
        vi = 0; oi = 0; cyc = 0; hold = 1'b0; held = '0;
        @(posedge clk); #1;
        bus.in_valid  = gap[0];
        bus.in_signed = vs[0];
        bus.din0      = va[0];
        bus.din1      = vb[0];
        bus.out_ready = pat[0];
        while (oi < NV && cyc < 400) begin
            @(negedge clk);
            if (hold) begin
                check_val("hold_valid", {31'h0, bus.out_valid}, 32'h1);
                check_val("hold_dout", {15'h0, bus.out_sat, bus.dout}, {15'h0, held});
            end
            check_val("in_ready", {31'h0, bus.in_ready},
                      {31'h0, !(bus.out_valid && !bus.out_ready)});
            if (bus.out_valid && bus.out_ready) begin
                check_val($sformatf("strm%0d", oi), {15'h0, bus.out_sat, bus.dout},
                          {15'h0, ve[oi]});
                oi++;
            end
            hold = bus.out_valid && !bus.out_ready;
            held = {bus.out_sat, bus.dout};
            acc  = bus.in_valid && bus.in_ready;
            @(posedge clk); #1;
            cyc++;
            if (acc) vi++;
            if (vi < NV) begin
                bus.in_valid  = gap[cyc % 16];
                bus.in_signed = vs[vi];
                bus.din0      = va[vi];
                bus.din1      = vb[vi];
            end else begin
                bus.in_valid = 1'b0;
            end
            bus.out_ready = pat[cyc % 32];
        end
        check_val("strm_count", oi, NV);
        check_val("strm_sat_cnt", {16'h0, bus.sat_cnt}, 32'd4);

        // Reset with samples in flight
        @(posedge clk); #1;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
        bus.in_valid  = 1'b1;
        bus.in_signed = 1'b1;
        bus.din0      = 16'h7FFF;
        bus.din1      = 16'h7FFF;
        repeat (3) @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        check_val("pre_rst_valid", {31'h0, bus.out_valid}, 32'h1);
        #1;
        reset = 1'b0;
        #1;
        check_val("arst_valid", {31'h0, bus.out_valid}, 32'h0);
        check_val("arst_cnt", {16'h0, bus.sat_cnt}, 32'h0);
        check_val("arst_sat", {31'h0, bus.out_sat}, 32'h0);
        check_val("arst_cnt_b", {30'h0, busb.sat_cnt}, 32'h0);
        @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk); #1;
        check_val("post_rst_ready", {31'h0, bus.in_ready}, 32'h1);
        stale = 0;
        repeat (10) begin
            @(negedge clk);
            if (bus.out_valid || busb.out_valid) stale++;
        end
        check_val("no_stale", stale, 0);
        send_one("post", 1'b1, 16'h0100, 16'h0100, 16'h0100, 1'b0, 16'h0100, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/full_pipeline_mul_stream.md
Name: full_pipeline_mul_stream

Overview:
- Next-generation pipelined multiplier for the image-processing datapath.
- Generalises the fixed-width, single-register signed multiplier in four ways: parametrised pipeline depth, per-sample signed/unsigned mode, valid/ready streaming handshake with backpressure, and fixed-point post-scaling (shift, round, saturate).
- Used by the convolution/gain stages, where products must be rescaled to pixel width and stalls propagate from downstream.

Parameters:
- DIN0_W, 16: width of operand A.
- DIN1_W, 16: width of operand B.
- DOUT_W, 16: result width.
- NUM_STAGE, 3: total latency in cycles, input accept to out_valid; legal range 1..8.
- SHIFT, 8: right-shift applied to the full product; legal range 0..DIN0_W+DIN1_W-1.
- ROUND_EN, 1: 1 = round half-up before the shift; 0 = truncate (floor).
- CNT_W, 16: width of the saturation event counter.

Ports:
- clk  in  1  clock; all logic is rising-edge.
- reset  in  1  asynchronous, active-low reset.
- in_valid  in  1  operands valid.
- in_ready  out  1  block can accept operands this cycle.
- in_signed  in  1  1 = both operands two's complement; 0 = both unsigned.
- din0  in  DIN0_W  operand A.
- din1  in  DIN1_W  operand B.
- out_valid  out  1  result valid.
- out_ready  in  1  downstream accepts the result.
- dout  out  DOUT_W  scaled, saturated result.
- out_sat  out  1  this result was clipped.
- sat_cnt  out  CNT_W  count of saturated results delivered.
- sat_clr  in  1  synchronous clear of sat_cnt.

Behaviour:
- Reset (reset=0, asynchronous): all stage valid bits, out_valid, dout, out_sat and sat_cnt are forced to 0. Stage data registers may be left uncleared. Any in-flight samples are discarded. in_ready=1 one cycle after reset release.
- Transfers:
  - Input transfer occurs when in_valid & in_ready.
  - Output transfer occurs when out_valid & out_ready.
- Pipeline advance: adv = !out_valid | out_ready.
  - All stages shift together when adv=1; the whole pipe holds when adv=0 (global stall).
  - in_ready = adv, combinationally.
  - A bubble (in_valid=0 while adv=1) inserts valid=0 into stage 1.
  - Bubbles are not compressed.
- Latency: with out_ready held at 1, a sample accepted at cycle t appears with out_valid=1 at cycle t+NUM_STAGE. Throughput is 1 sample per cycle.
- Hold rule: while out_valid=1 and out_ready=0, dout and out_sat are held stable.
- Arithmetic:
  - Full product P has width DIN0_W+DIN1_W+1. Operands are sign- or zero-extended according to in_signed, which is sampled together with the operands and carried down the pipe.
  - If ROUND_EN=1 and SHIFT>0, add 2^(SHIFT-1) to P before an arithmetic right shift by SHIFT.
  - Signed mode: clip to [-2^(DOUT_W-1), 2^(DOUT_W-1)-1].
  - Unsigned mode: clip to [0, 2^(DOUT_W-1+1)-1], i.e. [0, 2^DOUT_W-1].
  - out_sat=1 whenever clipping changed the value.
  - The rounding add must not wrap; compute it at full width plus one bit.
- Stage mapping: product in stage 1, round/shift in stage 2 if NUM_STAGE≥2, saturate in the last stage. Extra stages are delay registers. With NUM_STAGE=1, all three steps occur in one cycle.
- sat_cnt:
  - Increments by 1 on each output transfer with out_sat=1.
  - Sticks at 2^CNT_W-1 and does not wrap.
  - sat_clr=1 clears it to 0; if an increment coincides with sat_clr, clear wins and the result is 0.
- Stall mid-stream: no sample may be lost, duplicated or reordered across any pattern of out_ready.

Test Plan (defaults: DIN0_W=DIN1_W=DOUT_W=16, SHIFT=8, NUM_STAGE=3):
1. Latency and basic value: signed 0x0100×0x0100 at cycle 0, out_ready=1 -> out_valid at cycle 3, dout=0x0100, out_sat=0.
2. Rounding: signed 0x0180×0x0001 -> 0x0002 with ROUND_EN=1; 0x0001 with ROUND_EN=0. Signed 0xFFFF×0xFFFF (-1×-1) -> 0x0000.
3. Saturation and counter:
   - signed 0x7FFF×0x7FFF -> dout 0x7FFF, out_sat=1.
   - signed 0x8000×0x7FFF -> dout 0x8000, out_sat=1.
   - after both: sat_cnt=2; pulse sat_clr -> 0.
   - counter cap: CNT_W=2, 5 saturating samples -> sat_cnt=3.
4. Unsigned mode: 0xFFFF×0x0002 with in_signed=0 -> 0x0200, out_sat=0. Same operands with in_signed=1 -> 0x0000, since -1×2=-2 rounds to 0.
5. Backpressure: stream 20 random samples while out_ready toggles pseudo-randomly -> outputs bit-exact to the reference model in order; dout stable during out_ready=0; in_ready=0 exactly when out_valid=1 & out_ready=0.
6. Reset mid-stream: assert reset with 3 samples in flight -> out_valid and sat_cnt drop to 0 immediately (asynchronously); after release, no stale sample ever appears on the output.
